// File: rtl/jtag_ap_dr_ctrl.sv
`default_nettype none
`timescale 1ns / 1ps
// +--------------------------------------------------------------------------+
// | jtag_ap_dr_ctrl: TCK-side data register that feeds the AHB-AP command     |
// | FIFO on Update-DR and collects read responses on Capture-DR.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module jtag_ap_dr_ctrl #(
  parameter int CMD_W  = 41,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dr_select,
  input  logic              capture_dr,
  input  logic              shift_dr,
  input  logic              update_dr,
  input  logic              tdi,
  output logic              tdo,
  input  logic              wfull,
  output logic              winc,
  output logic [CMD_W-1:0]  wdata_fifo1,
  input  logic              rempty,
  output logic              rinc,
  input  logic [DATA_W-1:0] rdata_fifo2,
  output logic [CNT_W-1:0]  pending,
  output logic              overflow
);

  localparam int PAD_W = CMD_W - DATA_W - CNT_W - 2;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_SADDR = 2'b01,
    CMD_READ  = 2'b10,
    CMD_WRITE = 2'b11
  } cmd_e;

  logic [CMD_W-1:0] shreg_q, shreg_d;
  logic [CMD_W-1:0] wdata_q, wdata_d;
  logic             winc_q, winc_d;
  logic             rinc_q, rinc_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;

  logic do_update, do_capture, do_shift;
  cmd_e cmd;

  // Update wins over a simultaneous (illegal) capture.
  assign do_update  = update_dr & dr_select;
  assign do_capture = capture_dr & dr_select & ~update_dr;
  assign do_shift   = shift_dr & dr_select & ~do_capture;
  assign cmd        = cmd_e'(shreg_q[CMD_W-1 -: 2]);

  always_comb begin
    shreg_d    = shreg_q;
    wdata_d    = wdata_q;
    winc_d     = 1'b0;
    rinc_d     = 1'b0;
    pending_d  = pending_q;
    overflow_d = overflow_q;

    if (do_update) begin
      if (cmd != CMD_NOP) begin
        if (wfull || (cmd == CMD_READ && pending_q == {CNT_W{1'b1}})) begin
          overflow_d = 1'b1;
        end else begin
          winc_d  = 1'b1;
          wdata_d = shreg_q;
          if (cmd == CMD_READ) begin
            pending_d = pending_q + 1'b1;
          end
        end
      end
    end else if (do_capture) begin
      // Status fields reflect the values before this capture's own update.
      if (!rempty) begin
        shreg_d = {1'b1, overflow_q, {PAD_W{1'b0}}, pending_q, rdata_fifo2};
        rinc_d  = 1'b1;
        if (pending_q != '0) begin
          pending_d = pending_q - 1'b1;
        end
      end else begin
        shreg_d = {1'b0, overflow_q, {PAD_W{1'b0}}, pending_q, {DATA_W{1'b0}}};
      end
      overflow_d = 1'b0;
    end

    if (do_shift) begin
      shreg_d = {tdi, shreg_q[CMD_W-1:1]};
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      shreg_q    <= '0;
      wdata_q    <= '0;
      winc_q     <= 1'b0;
      rinc_q     <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      wdata_q    <= wdata_d;
      winc_q     <= winc_d;
      rinc_q     <= rinc_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign tdo         = shreg_q[0];
  assign winc        = winc_q;
  assign wdata_fifo1 = wdata_q;
  assign rinc        = rinc_q;
  assign pending     = pending_q;
  assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_ap_dr_ctrl.sv
`default_nettype none
`timescale 1ns / 1ps
// +--------------------------------------------------------------------------+
// | tb_jtag_ap_dr_ctrl: scoreboard bench with a command-level model.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_jtag_ap_dr_ctrl;
  localparam int CMD_W  = 41;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              nrst;
  logic              dr_select, capture_dr, shift_dr, update_dr, tdi, tdo;
  logic              wfull, winc, rempty, rinc, overflow;
  logic [CMD_W-1:0]  wdata_fifo1;
  logic [DATA_W-1:0] rdata_fifo2;
  logic [CNT_W-1:0]  pending;

  always #5 clk = ~clk;

  jtag_ap_dr_ctrl #(.CMD_W(CMD_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .CLK(clk), .nRST(nrst), .dr_select(dr_select), .capture_dr(capture_dr),
    .shift_dr(shift_dr), .update_dr(update_dr), .tdi(tdi), .tdo(tdo),
    .wfull(wfull), .winc(winc), .wdata_fifo1(wdata_fifo1), .rempty(rempty),
    .rinc(rinc), .rdata_fifo2(rdata_fifo2), .pending(pending), .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard queues and the command-level reference model.
  logic [CMD_W-1:0]  exp_w[$];
  logic [CMD_W-1:0]  exp_cap[$];
  int                exp_r = 0;
  logic [DATA_W-1:0] resp_q[$];
  int                m_pend = 0;
  bit                m_ov = 1'b0;
  logic [CMD_W-1:0]  m_word = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Show-ahead response FIFO environment; pops on rinc.
  initial begin
    rempty = 1'b1;
    rdata_fifo2 = '0;
    forever begin
      @(negedge clk);
      if (nrst && rinc && resp_q.size() > 0) void'(resp_q.pop_front());
      rempty = (resp_q.size() == 0);
      rdata_fifo2 = rempty ? '0 : resp_q[0];
    end
  end

  // Monitor: compares every winc/rinc pulse and every captured DR shift-out.
  initial begin
    bit prev_winc = 1'b0;
    bit collecting = 1'b0;
    int nbits = 0;
    logic [CMD_W-1:0] cap_word = '0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        prev_winc = 1'b0;
        collecting = 1'b0;
      end else begin
        if (winc) begin
          check("winc_expected", 64'(exp_w.size() != 0), 64'd1);
          if (exp_w.size() != 0) check("wdata", 64'(wdata_fifo1), 64'(exp_w.pop_front()));
          check("winc_single_cycle", 64'(prev_winc), 64'd0);
        end
        prev_winc = winc;
        if (rinc) begin
          check("rinc_expected", 64'(exp_r > 0), 64'd1);
          if (exp_r > 0) exp_r--;
        end
        if (collecting && shift_dr && dr_select) begin
          cap_word[nbits] = tdo;
          nbits++;
          if (nbits == CMD_W) begin
            collecting = 1'b0;
            check("capture_expected", 64'(exp_cap.size() != 0), 64'd1);
            if (exp_cap.size() != 0) check("capture_word", 64'(cap_word), 64'(exp_cap.pop_front()));
          end
        end
        if (capture_dr && dr_select && !update_dr) begin
          collecting = 1'b1;
          nbits = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_word(input logic [CMD_W-1:0] w, input bit sel);
    dr_select = sel;
    shift_dr = 1'b1;
    for (int i = 0; i < CMD_W; i++) begin
      tdi = w[i];
      tick();
    end
    shift_dr = 1'b0;
    dr_select = 1'b1;
    if (sel) m_word = w;
  endtask

  task automatic do_update(input bit sel, input bit with_capture);
    logic [1:0] c;
    c = m_word[CMD_W-1 -: 2];
    if (sel && c != 2'b00) begin
      if (wfull || (c == 2'b10 && m_pend == 15)) m_ov = 1'b1;
      else begin
        exp_w.push_back(m_word);
        if (c == 2'b10) m_pend++;
      end
    end
    dr_select = sel;
    update_dr = 1'b1;
    capture_dr = with_capture;
    tick();
    update_dr = 1'b0;
    capture_dr = 1'b0;
    dr_select = 1'b1;
    tick();
    check("pending_after_update", 64'(pending), 64'(m_pend));
    check("overflow_after_update", 64'(overflow), 64'(m_ov));
  endtask

  task automatic do_capture(input bit sel, input logic [CMD_W-1:0] next);
    if (sel) begin
      if (resp_q.size() > 0) begin
        exp_cap.push_back({1'b1, m_ov, 3'b000, CNT_W'(m_pend), resp_q[0]});
        exp_r++;
        if (m_pend > 0) m_pend--;
      end else begin
        exp_cap.push_back({1'b0, m_ov, 3'b000, CNT_W'(m_pend), 32'h0});
      end
      m_ov = 1'b0;
    end
    dr_select = sel;
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    dr_select = 1'b1;
    if (sel) shift_word(next, 1'b1);
    else tick();
    check("pending_after_capture", 64'(pending), 64'(m_pend));
    check("overflow_after_capture", 64'(overflow), 64'(m_ov));
  endtask

  task automatic send(input logic [1:0] c, input logic [31:0] payload, input logic [3:0] be, input bit full);
    shift_word({c, 3'b000, be, payload}, 1'b1);
    wfull = full;
    do_update(1'b1, 1'b0);
    wfull = 1'b0;
  endtask

  task automatic push_resp(input logic [DATA_W-1:0] d);
    resp_q.push_back(d);
    tick();
  endtask

  initial begin
    nrst = 1'b0;
    dr_select = 1'b0; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
    tdi = 1'b0; wfull = 1'b0;

    // Reset holds every output at zero whatever the inputs do.
    for (int i = 0; i < 8; i++) begin
      dr_select = 1'($urandom); capture_dr = 1'($urandom); shift_dr = 1'($urandom);
      update_dr = 1'($urandom); tdi = 1'($urandom); wfull = 1'($urandom);
      tick();
      check("rst_tdo", 64'(tdo), 64'd0);
      check("rst_winc", 64'(winc), 64'd0);
      check("rst_rinc", 64'(rinc), 64'd0);
      check("rst_wdata", 64'(wdata_fifo1), 64'd0);
      check("rst_pending", 64'(pending), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
    end
    dr_select = 1'b1; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
    tdi = 1'b0; wfull = 1'b0;
    tick();
    nrst = 1'b1;
    tick();

    do_capture(1'b1, {$urandom, $urandom});
    send(2'b11, 32'hDEADBEEF, 4'hF, 1'b0);
    send(2'b10, $urandom, 4'hF, 1'b0);
    push_resp(32'h12345678);
    do_capture(1'b1, {$urandom, $urandom});
    send(2'b11, $urandom, 4'h3, 1'b1);
    do_capture(1'b1, {$urandom, $urandom});
    send(2'b00, $urandom, 4'h0, 1'b0);
    send(2'b01, $urandom, 4'hF, 1'b0);

    // Deselected shift/update/capture must leave the loaded WRITE intact.
    shift_word({2'b11, 3'b000, 4'hA, 32'hCAFEF00D}, 1'b1);
    shift_word({$urandom, $urandom}, 1'b0);
    push_resp($urandom);
    do_update(1'b0, 1'b0);
    do_capture(1'b0, '0);
    do_update(1'b1, 1'b1);
    do_capture(1'b1, {$urandom, $urandom});

    // Pending saturation then one READ too many.
    while (m_pend < 15) send(2'b10, $urandom, 4'hF, 1'b0);
    send(2'b10, $urandom, 4'hF, 1'b0);

    for (int i = 0; i < 50; i++) begin
      case ($urandom_range(0, 3))
        0: send(2'($urandom), $urandom, 4'($urandom), ($urandom_range(0, 7) == 0));
        1: push_resp($urandom);
        2: do_capture(1'b1, {$urandom, $urandom});
        default: send(2'b10, $urandom, 4'hF, 1'b0);
      endcase
    end

    repeat (4) tick();
    check("exp_winc_drained", 64'(exp_w.size()), 64'd0);
    check("exp_rinc_drained", 64'(exp_r), 64'd0);
    check("exp_capture_drained", 64'(exp_cap.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
